// File: rtl/pkt_dsc_notif_ctrl_pkg.sv
// Shared types for the packet descriptor-notification controller.
package pkt_dsc_notif_ctrl_pkg;

  typedef enum logic [1:0] {
    DSC_MODE_REACTIVE = 2'd0,
    DSC_MODE_PER_PKT  = 2'd1,
    DSC_MODE_BATCHED  = 2'd2,
    DSC_MODE_RSVD     = 2'd3
  } pkt_dsc_mode_e;

  localparam int PKT_DSC_BATCH_WIDTH = 8;

  // Canonical per-queue state layout at the default counter width.
  typedef struct packed {
    logic                           outstanding;
    logic [PKT_DSC_BATCH_WIDTH-1:0] pending;
  } pkt_dsc_q_state_t;

  // The reserved encoding behaves exactly like reactive mode.
  function automatic pkt_dsc_mode_e pkt_dsc_mode_decode(input logic [1:0] raw);
    pkt_dsc_mode_e m;
    m = pkt_dsc_mode_e'(raw);
    return (m == DSC_MODE_RSVD) ? DSC_MODE_REACTIVE : m;
  endfunction

endpackage

// File: rtl/fifo_wrapper_infill_mlab.sv
// Show-ahead synchronous FIFO with occupancy count.
module fifo_wrapper_infill_mlab #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array write.
  // NOTE: storage arrays are never reset; only pointers/count carry validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pkt_dsc_state_ram.sv
// Per-queue state RAM: fixed-latency read plus a write-forwarding window
// so a read always observes writes committed while it was in flight.
module pkt_dsc_state_ram #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 9,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int WIN   = RD_LAT + 1;

  logic [DATA_WIDTH-1:0] mem       [DEPTH];
  logic [DATA_WIDTH-1:0] data_pipe [RD_LAT];
  logic [ADDR_WIDTH-1:0] addr_pipe [RD_LAT];
  logic                  win_vld   [WIN];
  logic [ADDR_WIDTH-1:0] win_addr  [WIN];
  logic [DATA_WIDTH-1:0] win_data  [WIN];

  // RAM array, read pipeline and window payload (no reset needed).
  // NOTE: non-blocking here means a same-edge read returns the old word;
  // the window below supplies the new one.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    data_pipe[0] <= mem[rd_addr];
    addr_pipe[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      data_pipe[i] <= data_pipe[i-1];
      addr_pipe[i] <= addr_pipe[i-1];
    end
    win_addr[0] <= wr_addr;
    win_data[0] <= wr_data;
    for (int i = 1; i < WIN; i++) begin
      win_addr[i] <= win_addr[i-1];
      win_data[i] <= win_data[i-1];
    end
  end

  // Window entry validity; cleared on reset so stale entries never match.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WIN; i++) win_vld[i] <= 1'b0;
    end else begin
      win_vld[0] <= wr_en;
      for (int i = 1; i < WIN; i++) win_vld[i] <= win_vld[i-1];
    end
  end

  // Newest matching window entry overrides RAM data (scan oldest first).
  // NOTE: rd_data gets a default before any conditional update, so no latch.
  always_comb begin
    rd_data = data_pipe[RD_LAT-1];
    for (int i = WIN-1; i >= 0; i--) begin
      if (win_vld[i] && (win_addr[i] == addr_pipe[RD_LAT-1])) rd_data = win_data[i];
    end
  end
endmodule

// File: rtl/pkt_dsc_notif_ctrl.sv
// Descriptor-notification controller: per beat, decides whether a
// descriptor is needed from per-queue state and the runtime mode.
module pkt_dsc_notif_ctrl
  import pkt_dsc_notif_ctrl_pkg::*;
#(
  parameter int NB_QUEUES      = 8192,
  parameter int QUEUE_ID_WIDTH = $clog2(NB_QUEUES),
  parameter int META_WIDTH     = 64,
  parameter int BATCH_WIDTH    = PKT_DSC_BATCH_WIDTH,
  parameter int STATUS_RD_LAT  = 2,
  parameter int OUT_FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [QUEUE_ID_WIDTH-1:0] in_queue_id,
  input  logic                      in_dsc_only,
  input  logic                      in_q_empty,
  input  logic                      in_drop,
  input  logic                      in_force_dsc,
  input  logic [META_WIDTH-1:0]     in_meta,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUEUE_ID_WIDTH-1:0] out_queue_id,
  output logic                      out_needs_dsc,
  output logic                      out_drop_meta,
  output logic [META_WIDTH-1:0]     out_meta,
  input  logic [1:0]                dsc_mode,
  input  logic [BATCH_WIDTH-1:0]    batch_size,
  output logic                      init_done,
  output logic [31:0]               dsc_cnt,
  output logic [31:0]               suppressed_cnt
);
  localparam int SW    = 1 + BATCH_WIDTH;
  localparam int PW    = BATCH_WIDTH + 1;
  localparam int CNT_W = $clog2(OUT_FIFO_DEPTH+1);

  // Same layout as pkt_dsc_q_state_t, sized by BATCH_WIDTH.
  typedef struct packed {
    logic                   outstanding;
    logic [BATCH_WIDTH-1:0] pending;
  } q_state_t;

  typedef struct packed {
    logic                      valid;
    logic [QUEUE_ID_WIDTH-1:0] qid;
    logic                      dsc_only;
    logic                      q_empty;
    logic                      drop;
    logic                      force_dsc;
    logic [META_WIDTH-1:0]     meta;
  } beat_t;

  typedef struct packed {
    logic [QUEUE_ID_WIDTH-1:0] qid;
    logic                      needs;
    logic                      drop_meta;
    logic [META_WIDTH-1:0]     meta;
  } out_t;

  logic [QUEUE_ID_WIDTH-1:0] init_addr;
  beat_t                     pipe [STATUS_RD_LAT];
  beat_t                     dec;
  logic [SW-1:0]             ram_rd_data;
  q_state_t                  cur_st, nxt_st;
  logic                      needs, drop_meta;
  pkt_dsc_mode_e             mode;
  logic [BATCH_WIDTH-1:0]    bs_eff;
  logic [PW-1:0]             pend_sum;
  logic                      out_reg_vld, out_reg_sup;
  out_t                      out_reg, fifo_q;
  logic                      fifo_empty, fifo_full;
  logic [CNT_W-1:0]          fifo_count;
  int unsigned               in_flight;
  logic                      accept;

  assign dec    = pipe[STATUS_RD_LAT-1];
  assign accept = in_valid & in_ready;

  // Admission: reserve FIFO room for every beat already in the pipeline.
  always_comb begin
    in_flight = 32'(out_reg_vld);
    for (int i = 0; i < STATUS_RD_LAT; i++) in_flight = in_flight + 32'(pipe[i].valid);
    in_ready = init_done & ~fifo_full &
               ((32'(fifo_count) + in_flight) <= 32'(OUT_FIFO_DEPTH - 1));
  end

  // Init sweep: clear one queue state per cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      init_addr <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      init_addr <= init_addr + QUEUE_ID_WIDTH'(1);
      if (init_addr == QUEUE_ID_WIDTH'(NB_QUEUES - 1)) init_done <= 1'b1;
    end
  end

  // Beat pipeline aligned with the state RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STATUS_RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: accept, qid: in_queue_id, dsc_only: in_dsc_only,
                   q_empty: in_q_empty, drop: in_drop, force_dsc: in_force_dsc,
                   meta: in_meta};
      for (int i = 1; i < STATUS_RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  pkt_dsc_state_ram #(
    .ADDR_WIDTH (QUEUE_ID_WIDTH),
    .DATA_WIDTH (SW),
    .RD_LAT     (STATUS_RD_LAT)
  ) u_state_ram (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (in_queue_id),
    .rd_data (ram_rd_data),
    .wr_en   (~init_done | dec.valid),
    .wr_addr (init_done ? dec.qid : init_addr),
    .wr_data (init_done ? nxt_st : '0)
  );

  // Decision: priority-ordered rules over current queue state and mode.
  always_comb begin
    cur_st    = q_state_t'(ram_rd_data);
    nxt_st    = cur_st;
    needs     = 1'b0;
    drop_meta = 1'b0;
    mode      = pkt_dsc_mode_decode(dsc_mode);
    bs_eff    = (batch_size == '0) ? BATCH_WIDTH'(1) : batch_size;
    pend_sum  = {1'b0, cur_st.pending} + PW'(1);
    if (dec.force_dsc) begin
      needs  = 1'b1;
      nxt_st = '{outstanding: 1'b1, pending: '0};
    end else if (dec.dsc_only) begin
      needs     = ~dec.q_empty;
      drop_meta = dec.q_empty;
      nxt_st    = '{outstanding: ~dec.q_empty, pending: '0};
    end else if (dec.drop) begin
      drop_meta = 1'b1;
    end else begin
      case (mode)
        DSC_MODE_PER_PKT: begin
          needs  = 1'b1;
          nxt_st = '0;
        end
        DSC_MODE_BATCHED: begin
          if (!cur_st.outstanding && (pend_sum >= {1'b0, bs_eff})) begin
            needs  = 1'b1;
            nxt_st = '{outstanding: 1'b1, pending: '0};
          end else begin
            nxt_st.pending = pend_sum[BATCH_WIDTH] ? cur_st.pending : pend_sum[BATCH_WIDTH-1:0];
          end
        end
        default: begin
          needs  = ~cur_st.outstanding;
          nxt_st = '{outstanding: 1'b1, pending: '0};
        end
      endcase
    end
  end

  // Registered decision result, written into the output FIFO next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_reg_vld <= 1'b0;
      out_reg_sup <= 1'b0;
      out_reg     <= '0;
    end else begin
      out_reg_vld <= dec.valid;
      out_reg_sup <= dec.valid & ~dec.dsc_only & ~dec.drop & ~needs;
      out_reg     <= '{qid: dec.qid, needs: needs, drop_meta: drop_meta, meta: dec.meta};
    end
  end

  // Statistics counted at FIFO write time; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dsc_cnt        <= '0;
      suppressed_cnt <= '0;
    end else if (out_reg_vld) begin
      dsc_cnt        <= dsc_cnt + 32'(out_reg.needs);
      suppressed_cnt <= suppressed_cnt + 32'(out_reg_sup);
    end
  end

  fifo_wrapper_infill_mlab #(
    .WIDTH ($bits(out_t)),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (out_reg_vld),
    .wr_data (out_reg),
    .rd_en   (out_valid & out_ready),
    .rd_data (fifo_q),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign out_valid     = ~fifo_empty;
  assign out_queue_id  = fifo_q.qid;
  assign out_needs_dsc = fifo_q.needs;
  assign out_drop_meta = fifo_q.drop_meta;
  assign out_meta      = fifo_q.meta;
endmodule
